filter_capture: RTL
===================

# filter_capture

Capture and measurement block for the output end of the `iir_N` filter stream. It consumes one signed sample per clock from the filter's `y` output and stores a window of `DEPTH` samples in an internal buffer. It also keeps running min, max and sum over that window. After capture, the buffer and statistics are read out through a synchronous read port, so filter response can be checked in hardware rather than by printing every sample.

## Interface
- `BITWIDTH`, 32: sample width, signed two's complement; matches the filter `BITWIDTH`.
- `DEPTH`, 64: samples per capture window; power of two, at least 2.
- `SKIP`, 0: samples discarded after arm before capture begins (settling); range 0..65535.
- `AW` (localparam) = clog2(DEPTH); `SUMW` (localparam) = BITWIDTH+AW.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `y_in`  in  BITWIDTH  signed filter output sample, taken every clock while capturing.
- `arm`  in  1  single-cycle start request.
- `busy`  out  1  high in SKIP and CAPTURE states.
- `done`  out  1  high in DONE state (level).
- `count`  out  AW+1  number of samples stored in the current window.
- `min_val` / `max_val`  out  BITWIDTH  signed minimum / maximum of the stored samples.
- `sum_val`  out  SUMW  signed sum of the stored samples.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  buffer index to read.
- `rd_data`  out  BITWIDTH  read result.
- `rd_valid`  out  1  high for one cycle, one clock after `rd_en`.

## Operation
- States: IDLE, SKIP, CAPTURE, DONE.
- IDLE: wait for `arm`. On `arm`, clear `count`, `sum_val`, `min_val` and `max_val`, then go to SKIP (`SKIP`>0) or CAPTURE (`SKIP`=0).
- SKIP: discard `y_in` for exactly `SKIP` clocks, then go to CAPTURE.
- CAPTURE: each clock:
  - write `y_in` to `mem[count]` and increment `count`;
  - `sum_val += sign-extended y_in`;
  - first sample sets `min_val` = `max_val` = `y_in`; later samples use signed compare.
  - When `count` reaches `DEPTH`, go to DONE.
- DONE: results hold. `arm` restarts exactly as from IDLE.
- `arm` in SKIP or CAPTURE is ignored; the window is not restarted.
- Sum cannot overflow: SUMW bits hold DEPTH full-scale samples.
- Read port:
  - Works in every state.
  - `rd_addr` < `count` returns the stored sample.
  - `rd_addr` >= `count` returns 0.
  - A read of the slot being written in the same clock returns 0, since the address is not yet counted.
  - `rd_en` may be asserted every clock, giving full throughput.
- `rst` at any time, including mid-capture, forces IDLE and clears all outputs. Buffer contents become unreadable because `count`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `min_val`=0, `max_val`=0, `sum_val`=0, `rd_data`=0, `rd_valid`=0.
- Capture latency, with `arm` sampled high at edge k:
  - `busy`=1 after edge k.
  - `y_in` is captured at edges k+1+SKIP .. k+SKIP+DEPTH.
  - `done`=1 and `busy`=0 after edge k+SKIP+DEPTH.
- Status update timing: `count` and the statistics update in the same edge as each capture and include that sample immediately after the edge.
- Read latency: `rd_en` at edge r gives `rd_data`/`rd_valid` after edge r+1. Without `rd_en`, `rd_valid`=0 and `rd_data` holds its last value.
- Simultaneous `rst` and `arm`: `rst` wins.
- Simultaneous `arm` and the final capture edge: the final sample is stored and the `arm` is ignored.

## Test plan
- Ramp (DEPTH=8, SKIP=0): arm, then `y_in`=1..8 on consecutive clocks. Require:
  - `done` exactly 8 clocks after arm;
  - `count`=8, `min_val`=1, `max_val`=8, `sum_val`=36;
  - reads of addr 0..7 return 1..8, each with `rd_valid` one clock after `rd_en`.
- Signed data (DEPTH=8): samples 25, 10, 25, 10, 67, -56, 19, 28. Require `min_val`=-56, `max_val`=67, `sum_val`=128; addr 5 reads back -56.
- Settling skip (DEPTH=4, SKIP=2): `y_in`=100, 200, 1, 2, 3, 4. Require the buffer to hold 1..4, `sum_val`=10, and `busy` high for 6 clocks.
- Reset and re-arm (DEPTH=8):
  - `rst` after 3 captured samples → next clock all outputs are 0 and state is IDLE; a read of addr 0 returns 0.
  - Re-arm with all samples -1 → `sum_val`=-8, `min_val`=`max_val`=-1.
- Boundaries:
  - `arm` pulsed mid-capture has no effect; `done` timing is unchanged.
  - `arm` in DONE clears the stats and restarts.
  - Full-scale samples (DEPTH=8, all 0x7FFFFFFF) → `sum_val`=0x3_FFFF_FFF8 with no wrap.
  - During capture, reading addr 7 with `count`=3 returns 0.

Source files
------------

// File: rtl/filter_capture.sv
// rtl/filter_capture.sv - capture window of filter output samples with running min/max/sum and readback
module filter_capture #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 64,
  parameter int SKIP     = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int SUMW    = BITWIDTH + AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [BITWIDTH-1:0] y_in,
  input  logic                       arm,
  output logic                       busy,
  output logic                       done,
  output logic [AW:0]                count,
  output logic signed [BITWIDTH-1:0] min_val,
  output logic signed [BITWIDTH-1:0] max_val,
  output logic signed [SUMW-1:0]     sum_val,
  input  logic                       rd_en,
  input  logic [AW-1:0]              rd_addr,
  output logic signed [BITWIDTH-1:0] rd_data,
  output logic                       rd_valid
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [15:0]   SKIP_LAST = 16'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                skip_cnt;
  logic signed [BITWIDTH-1:0] mem [DEPTH];
  logic                       start;
  logic                       capture;
  logic signed [SUMW-1:0]     y_ext;

  assign y_ext = {{AW{y_in[BITWIDTH-1]}}, y_in};
  assign busy  = (state_q == S_SKIP) || (state_q == S_CAPTURE);
  assign done  = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          start   = 1'b1;
          state_d = (SKIP > 0) ? S_SKIP : S_CAPTURE;
        end
      end
      S_SKIP: begin
        if (skip_cnt == SKIP_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // arm is deliberately not looked at here, so a window is never restarted
        capture = 1'b1;
        if (count == LAST_IDX) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (capture) mem[count[AW-1:0]] <= y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      min_val  <= '0;
      max_val  <= '0;
      sum_val  <= '0;
      skip_cnt <= '0;
    end else if (start) begin
      count    <= '0;
      min_val  <= '0;
      max_val  <= '0;
      sum_val  <= '0;
      skip_cnt <= '0;
    end else if (state_q == S_SKIP) begin
      skip_cnt <= skip_cnt + 16'd1;
    end else if (capture) begin
      count   <= count + CW'(1);
      sum_val <= sum_val + y_ext;
      if (count == '0 || y_in < min_val) min_val <= y_in;
      if (count == '0 || y_in > max_val) max_val <= y_in;
    end
  end

  // Reads compare against the registered count, so the slot written this clock reads as 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_addr} < count) ? mem[rd_addr] : '0;
    end
  end

endmodule
